// File: rtl/toggle_event_rx.sv
// Rebuilds events from a toggle-encoded line: sync, edge detect, saturating pending count, valid/ready out.
// Latency: a level change shows on evt_valid SYNC_STAGES+1 clk edges after it is first sampled.
// Backpressure: events accumulate while evt_ready is low; once full, new events are dropped and overflow is set.
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOTAL_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tog_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CNT_W-1:0]   pending,
    output logic               overflow,
    input  logic               clr_ovf,
    output logic [TOTAL_W-1:0] evt_total
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int                INIT_W    = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic [0:0]             state_q,    state_d;
    logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
    logic                   prev_q,     prev_d;
    logic [CNT_W-1:0]       pend_q,     pend_d;
    logic                   ovf_q,      ovf_d;
    logic [TOTAL_W-1:0]     total_q,    total_d;

    logic edge_det;
    logic pop;
    logic drop;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // INIT only tracks the line so a level already present at reset release is not seen as a change.
    assign edge_det  = (state_q == ST_RUN) && (sync_last ^ prev_q);

    assign evt_valid = (pend_q != '0);
    assign pop       = evt_valid & evt_ready;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = sync_last;
        pend_d     = pend_q;
        ovf_d      = ovf_q;
        total_d    = total_q;
        drop       = 1'b0;

        if (state_q == ST_INIT) begin
            if (init_cnt_q == INIT_LAST) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
            end
        end

        if (pop) begin
            total_d = total_q + TOTAL_W'(1);
        end

        // A simultaneous pop frees a slot, so a full buffer still accepts the incoming event.
        if (edge_det && !pop) begin
            if (pend_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (pop && !edge_det) begin
            pend_d = pend_q - CNT_W'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prev_q     <= 1'b0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            total_q    <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tog_in};
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            total_q    <= total_d;
        end
    end

    assign pending   = pend_q;
    assign overflow  = ovf_q;
    assign evt_total = total_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Randomized scoreboard bench for toggle_event_rx with an event-level reference model.
module tb_toggle_event_rx;

    localparam int S    = 3;
    localparam int CW   = 2;
    localparam int TW   = 4;
    localparam int MAXP = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tog_in = 1'b1;
    logic          evt_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          evt_valid;
    logic [CW-1:0] pending;
    logic          overflow;
    logic [TW-1:0] evt_total;

    toggle_event_rx #(
        .SYNC_STAGES(S),
        .CNT_W      (CW),
        .TOTAL_W    (TW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tog_in   (tog_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .evt_total(evt_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pend;
        int vld;
        int ovf;
        int total;
    } snap_t;

    snap_t exp_q[$];
    int    pop_q[$];
    int    tog_hist[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int run_start = 0;
    int last_tog = -100;
    bit started = 1'b0;
    bit armed = 1'b0;

    int m_pend = 0;
    int m_ovf = 0;
    int m_total = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock cycle: record what the outputs must show now, drive inputs, advance the model.
    task automatic step(input bit flip, input bit rdy, input bit clr, input bit rst);
        bit arrive;
        bit popm;
        bit dropm;
        if (started) exp_q.push_back('{m_pend, int'(m_pend != 0), m_ovf, m_total});
        if (flip) begin
            tog_in = ~tog_in;
            tog_hist.push_back(cyc);
            last_tog = cyc;
        end
        evt_ready = rdy;
        clr_ovf   = clr;
        reset     = rst;
        if (rst) begin
            m_pend = 0;
            m_ovf = 0;
            m_total = 0;
            tog_hist.delete();
            run_start = cyc + S + 2;
            started = 1'b1;
        end else begin
            arrive = 1'b0;
            dropm = 1'b0;
            if (tog_hist.size() > 0 && tog_hist[0] + S == cyc) begin
                void'(tog_hist.pop_front());
                arrive = (cyc >= run_start);
            end
            popm = (m_pend != 0) && rdy;
            if (popm) begin
                m_total = (m_total + 1) % (1 << TW);
                pop_q.push_back(cyc);
            end
            if (arrive && !popm) begin
                if (m_pend == MAXP) dropm = 1'b1;
                else m_pend++;
            end else if (popm && !arrive) begin
                m_pend--;
            end
            if (dropm) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) armed = 1'b1;
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pending",   int'(pending),   e.pend);
            check("evt_valid", int'(evt_valid), e.vld);
            check("overflow",  int'(overflow),  e.ovf);
            check("evt_total", int'(evt_total), e.total);
        end
        if (armed && !reset && evt_valid && evt_ready) begin
            if (pop_q.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                check("pop_cycle", cyc, pop_q.pop_front());
            end
        end
    end

    initial begin
        int lat;
        int lat_t;
        bit f;

        // Line already high through reset must not create an event.
        repeat (3) step(0, 0, 0, 1);
        repeat (S + 8) step(0, 0, 0, 0);
        check("no_false_event", int'(pending), 0);

        repeat (3) begin
            step(1, 0, 0, 0);
            repeat (3) step(0, 0, 0, 0);
        end
        repeat (6) step(0, 0, 0, 0);
        check("three_pending", int'(pending), 3);
        repeat (5) step(0, 1, 0, 0);
        check("three_delivered", int'(evt_total), 3);
        check("drained_valid", int'(evt_valid), 0);

        repeat (4) begin
            step(1, 0, 0, 0);
            repeat (2) step(0, 0, 0, 0);
        end
        repeat (6) step(0, 0, 0, 0);
        check("full_pending", int'(pending), MAXP);
        check("ovf_set", int'(overflow), 1);
        step(0, 0, 1, 0);
        check("ovf_cleared", int'(overflow), 0);

        // Arrival lands exactly on the cycle a pop is taken from the full buffer.
        step(1, 0, 0, 0);
        repeat (S - 1) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        check("full_edge_pop_pending", int'(pending), MAXP);
        check("full_edge_pop_ovf", int'(overflow), 0);

        repeat (5) step(0, 1, 0, 0);
        lat_t = cyc;
        step(1, 0, 0, 0);
        lat = -1;
        for (int i = 0; i < 12 && lat < 0; i++) begin
            if (evt_valid) lat = cyc - lat_t;
            else step(0, 0, 0, 0);
        end
        check("latency", lat, S + 1);

        step(0, 1, 0, 1);
        check("rst_pending", int'(pending), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_total", int'(evt_total), 0);
        repeat (S + 4) step(0, 0, 0, 0);
        check("after_init_pending", int'(pending), 0);

        repeat (17) begin
            step(1, 1, 0, 0);
            repeat (2) step(0, 1, 0, 0);
        end
        repeat (8) step(0, 1, 0, 0);
        check("total_wrap", int'(evt_total), 1);

        for (int i = 0; i < 2500; i++) begin
            f = (cyc - last_tog >= 2) && ($urandom_range(2) == 0);
            if ($urandom_range(299) == 0) step(0, $urandom_range(1), 0, 1);
            else step(f, $urandom_range(1), ($urandom_range(15) == 0), 0);
        end

        repeat (S + 12) step(0, 1, 0, 0);
        #5;
        check("pops_all_seen", pop_q.size(), 0);
        check("snaps_all_seen", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
